move_unit: RTL

- Pipelined, parametrised move execution unit; successor to the single-cycle combinational move op in the ALU.
- Adds four move modes (MOV, MVN, MOVZ, MOVK), lane-granular immediate insertion, registered NZCV flags, configurable pipeline depth and valid/ready handshakes on both sides.
- Sits in the execute stage beside the arithmetic units; the writeback arbiter consumes its output.

---
 rtl/move_unit_if.sv | 33 +++
 rtl/move_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/move_unit_if.sv
// rtl/move_unit_if.sv - request/response bundle for the move execution unit
//
// Request side : in_valid, in_ready, op, a, imm, sel
// Response side: out_valid, out_ready, result, flags
// Modports     : master = requester/consumer, slave = the move unit
interface move_unit_if #(
    parameter int N      = 32,
    parameter int LANE_W = 8
);
    localparam int LANES = N / LANE_W;
    localparam int SW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [N-1:0]      a;
    logic [LANE_W-1:0] imm;
    logic [SW-1:0]     sel;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      result;
    logic [3:0]        flags;

    modport master (
        output in_valid, op, a, imm, sel, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, imm, sel, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/move_unit.sv
// rtl/move_unit.sv - pipelined MOV/MVN/MOVZ/MOVK execution unit with NZCV flags
//
// Parameters: N (datapath width), LANE_W (immediate lane width, divides N),
//             STAGES (1..4, accept-to-output latency in cycles)
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   bus   - move_unit_if.slave: in_valid/in_ready/op/a/imm/sel request,
//           out_valid/out_ready/result/flags response
//   busy  - any pipeline stage occupied
module move_unit #(
    parameter int N      = 32,
    parameter int LANE_W = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    move_unit_if.slave   bus,
    output logic         busy
);
    localparam int LANES = N / LANE_W;
    localparam int SW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_MVN  = 2'b01;
    localparam logic [1:0] OP_MOVZ = 2'b10;
    localparam logic [1:0] OP_MOVK = 2'b11;

    logic [N-1:0] imm_placed;
    logic [N-1:0] lane_mask;
    logic [N-1:0] new_result;
    logic [3:0]   new_flags;

    // Lane decode by comparison: an out-of-range sel matches no lane, so
    // MOVZ yields zero and MOVK leaves a untouched without extra logic.
    always_comb begin
        imm_placed = '0;
        lane_mask  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (bus.sel == SW'(l)) begin
                imm_placed[l*LANE_W +: LANE_W] = bus.imm;
                lane_mask[l*LANE_W +: LANE_W]  = '1;
            end
        end
    end

    always_comb begin
        new_result = bus.a;
        case (bus.op)
            OP_MOV:  new_result = bus.a;
            OP_MVN:  new_result = ~bus.a;
            OP_MOVZ: new_result = imm_placed;
            OP_MOVK: new_result = (bus.a & ~lane_mask) | imm_placed;
            default: new_result = bus.a;
        endcase
        new_flags = {new_result[N-1], (new_result == '0), 2'b00};
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [N-1:0]      data [STAGES];
    logic [3:0]        flg  [STAGES];

    // Ready ripples back from the consumer: a stage may load when it is
    // empty or when its occupant moves on in the same cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !vld[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !vld[k] || adv[k+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld[0]  <= 1'b0;
            data[0] <= '0;
            flg[0]  <= '0;
        end else if (adv[0]) begin
            vld[0] <= bus.in_valid;
            if (bus.in_valid) begin
                data[0] <= new_result;
                flg[0]  <= new_flags;
            end
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld[k]  <= 1'b0;
                data[k] <= '0;
                flg[k]  <= '0;
            end else if (adv[k]) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    data[k] <= data[k-1];
                    flg[k]  <= flg[k-1];
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.result    = data[STAGES-1];
    assign bus.flags     = flg[STAGES-1];
    assign busy          = |vld;
endmodule
